// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Memory-access stage between the multicycle control FSM and the unified
// instruction/data memory. The controller issues one access per FSM step
// (acc_valid); this block latches the request, runs a req/ack handshake with a
// variable-latency memory and deposits the result into IR (fetch) or MDR
// (load). Stores latch nothing. Misaligned addresses never reach the memory
// and complete immediately with err=1. A request that sees no ack for TIMEOUT
// cycles is dropped and completes with err=1.
//
// Parameters
//   TIMEOUT   max cycles spent requesting without an ack; 0 disables the abort
//   CNT_W     wait counter width, 2**CNT_W > TIMEOUT
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   acc_valid              access strobe, only looked at while idle
//   IorD, MemWrite         0 = fetch at pc, 1 = data at aluout; store if both 1
//   pc, aluout, wdata      fetch address, data address, store data
//   mem_req/we/addr/wdata  memory request side, held stable until mem_ack
//   mem_ack, mem_rdata     memory completion, read data valid with ack
//   instr, Op, Funct       IR and its opcode/function fields
//   mdr                    memory data register
//   busy                   stall to controller (combinational)
//   done, err              one-cycle completion pulse and its status
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        acc_valid,
  input  logic        IorD,
  input  logic        MemWrite,
  input  logic [31:0] pc,
  input  logic [31:0] aluout,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  Op,
  output logic [5:0]  Funct,
  output logic [31:0] mdr,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
  typedef enum logic [1:0] {K_FETCH, K_LOAD, K_STORE} kind_t;

  // Latched request, captured once at acceptance and held through S_REQ.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    kind_t       kind;
  } req_t;

  state_t             state_q, state_d;
  req_t               req_q, req_d;
  logic               mem_req_q, mem_req_d;
  logic [31:0]        instr_q, instr_d;
  logic [31:0]        mdr_q, mdr_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [31:0]        addr_sel;
  logic               wr_sel;
  logic               timeout_hit;

  // cnt_q holds the number of S_REQ cycles already completed, so the
  // TIMEOUT-th requesting cycle is the one where cnt_q == TIMEOUT-1.
  generate
    if (TIMEOUT == 0) begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end else begin : g_timeout
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
      assign timeout_hit = (cnt_q == CNT_LAST);
    end
  endgenerate

  // MemWrite without IorD is not a store: it falls back to a plain fetch.
  assign addr_sel = IorD ? aluout : pc;
  assign wr_sel   = IorD & MemWrite;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    mem_req_d = mem_req_q;
    instr_d   = instr_q;
    mdr_d     = mdr_q;
    err_d     = err_q;
    cnt_d     = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (acc_valid) begin
          req_d.addr  = {addr_sel[31:2], 2'b00};
          req_d.wdata = wdata;
          req_d.kind  = wr_sel ? K_STORE : (IorD ? K_LOAD : K_FETCH);
          cnt_d       = '0;
          if (addr_sel[1:0] != 2'b00) begin
            // Never reaches the memory; err is set now so it shows with done.
            req_d.we  = 1'b0;
            mem_req_d = 1'b0;
            err_d     = 1'b1;
            state_d   = S_DONE;
          end else begin
            req_d.we  = wr_sel;
            mem_req_d = 1'b1;
            state_d   = S_REQ;
          end
        end
      end

      S_REQ: begin
        // An ack arriving in the timeout cycle still counts as success.
        if (mem_ack) begin
          case (req_q.kind)
            K_FETCH: instr_d = mem_rdata;
            K_LOAD:  mdr_d   = mem_rdata;
            default: ;
          endcase
          mem_req_d = 1'b0;
          req_d.we  = 1'b0;
          err_d     = 1'b0;
          state_d   = S_DONE;
        end else if (timeout_hit) begin
          mem_req_d = 1'b0;
          req_d.we  = 1'b0;
          err_d     = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        mem_req_d = 1'b0;
        req_d.we  = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      req_q     <= '{addr: 32'h0, wdata: 32'h0, we: 1'b0, kind: K_FETCH};
      mem_req_q <= 1'b0;
      instr_q   <= 32'h0;
      mdr_q     <= 32'h0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      mem_req_q <= mem_req_d;
      instr_q   <= instr_d;
      mdr_q     <= mdr_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = req_q.we;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign instr     = instr_q;
  assign Op        = instr_q[31:26];
  assign Funct     = instr_q[5:0];
  assign mdr       = mdr_q;
  assign err       = err_q;
  assign done      = (state_q == S_DONE);
  // Stall already in the accepting cycle so the controller holds its step.
  assign busy      = ((state_q == S_IDLE) & acc_valid) | (state_q == S_REQ) |
                     (state_q == S_DONE);

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        acc_valid, IorD, MemWrite;
  logic [31:0] pc, aluout, wdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instr, mdr;
  logic [5:0]  Op, Funct;
  logic        busy, done, err;

  int checks = 0;
  int errors = 0;

  // Reference state: what IR/MDR must hold after the accesses so far.
  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_mdr   = 32'h0;

  typedef struct {
    int req;
    int dcyc;
    bit err;
  } exp_t;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .acc_valid(acc_valid), .IorD(IorD), .MemWrite(MemWrite),
    .pc(pc), .aluout(aluout), .wdata(wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr(instr), .Op(Op), .Funct(Funct), .mdr(mdr),
    .busy(busy), .done(done), .err(err)
  );

  // Reference: outcome of one access from the transaction rules, plus IR/MDR update.
  // ack_at = requesting cycle (1-based) in which memory acks; 0 = never.
  task automatic model_access(input bit iord, input bit mw, input logic [31:0] a_pc,
                              input logic [31:0] a_alu, input int ack_at,
                              input logic [31:0] rd, output exp_t e);
    logic [31:0] a;
    bit acked;
    a = iord ? a_alu : a_pc;
    if (a % 4 != 0) begin
      e.req = 0; e.dcyc = 1; e.err = 1'b1;
    end else begin
      acked  = (ack_at >= 1) && (ack_at <= TO);
      e.req  = acked ? ack_at : TO;
      e.dcyc = e.req + 1;
      e.err  = !acked;
      if (acked && !iord) m_instr = rd;
      if (acked && iord && !mw) m_mdr = rd;
    end
  endtask

  // Bench acting as controller + memory. Reports what it observed; viol counts
  // cycles where busy/request fields/ordering broke the handshake rules.
  task automatic run_access(input bit iord, input bit mw, input logic [31:0] a_pc,
                            input logic [31:0] a_alu, input logic [31:0] a_wd,
                            input int ack_at, input logic [31:0] rd, input bit noise,
                            output int req_n, output int done_cyc, output bit err_o,
                            output bit err_hold, output int viol);
    logic [31:0] e_addr;
    bit e_we;
    e_addr = iord ? a_alu : a_pc;
    e_we = iord & mw;
    viol = 0; req_n = 0; done_cyc = -1; err_o = 1'b0;
    @(negedge clk);
    IorD = iord; MemWrite = mw; pc = a_pc; aluout = a_alu; wdata = a_wd; acc_valid = 1'b1;
    #1;
    if (busy !== 1'b1) viol++;
    @(posedge clk); #1 acc_valid = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (busy !== 1'b1) viol++;
      if (done === 1'b1) begin
        done_cyc = cyc;
        err_o = err;
        if (mem_req !== 1'b0) viol++;
      end else if (mem_req === 1'b1) begin
        req_n++;
        if (mem_addr !== e_addr || mem_we !== e_we || (e_we && mem_wdata !== a_wd)) viol++;
        if (req_n == ack_at) begin mem_ack = 1'b1; mem_rdata = rd; end
        else mem_rdata = $urandom;
      end else begin
        viol++;
      end
      if (noise && done_cyc < 0) begin
        acc_valid = 1'b1; pc = $urandom; aluout = $urandom; IorD = 1'($urandom);
        MemWrite = 1'($urandom); wdata = $urandom;
      end
      if (done_cyc >= 0) acc_valid = 1'b0;
      @(posedge clk); #1 mem_ack = 1'b0;
      if (done_cyc >= 0) break;
    end
    acc_valid = 1'b0;
    @(negedge clk);
    if (busy !== 1'b0 || done !== 1'b0 || mem_req !== 1'b0) viol++;
    err_hold = err;
  endtask

  task automatic test_reset();
    rst = 1'b1; acc_valid = 1'b0; IorD = 1'b0; MemWrite = 1'b0;
    pc = 32'h0; aluout = 32'h0; wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, done, err, busy} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 00000", {mem_req, mem_we, done, err, busy});
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || instr !== 32'h0 || mdr !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got addr=%h wd=%h ir=%h mdr=%h exp all 0", mem_addr, mem_wdata, instr, mdr);
    end
  endtask

  task automatic test_fetch();
    int rq, dc, v; bit e, eh; exp_t x;
    model_access(1'b0, 1'b0, 32'h0000_3000, 32'h0, 1, 32'h2008_0005, x);
    run_access(1'b0, 1'b0, 32'h0000_3000, 32'h0, 32'h0, 1, 32'h2008_0005, 1'b0, rq, dc, e, eh, v);
    checks++; if (instr !== 32'h2008_0005) begin errors++; $display("FAIL fetch_instr got %h exp 20080005", instr); end
    checks++; if (Op !== 6'h08 || Funct !== 6'h05) begin errors++; $display("FAIL fetch_fields got op=%h fn=%h exp 08 05", Op, Funct); end
    checks++; if (dc !== 2 || e !== 1'b0) begin errors++; $display("FAIL fetch_done got cyc=%0d err=%0d exp 2 0", dc, e); end
    checks++; if (rq !== x.req || v !== 0) begin errors++; $display("FAIL fetch_hs got req=%0d viol=%0d exp %0d 0", rq, v, x.req); end
  endtask

  task automatic test_load();
    int rq, dc, v; bit e, eh; exp_t x;
    model_access(1'b1, 1'b0, 32'h0, 32'h10, 5, 32'hDEAD_BEEF, x);
    run_access(1'b1, 1'b0, 32'h0, 32'h10, 32'h0, 5, 32'hDEAD_BEEF, 1'b0, rq, dc, e, eh, v);
    checks++; if (mdr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_mdr got %h exp deadbeef", mdr); end
    checks++; if (instr !== m_instr) begin errors++; $display("FAIL load_instr got %h exp %h", instr, m_instr); end
    checks++; if (dc !== x.dcyc || rq !== 5 || e !== 1'b0 || v !== 0) begin
      errors++; $display("FAIL load_hs got cyc=%0d req=%0d err=%0d viol=%0d exp %0d 5 0 0", dc, rq, e, v, x.dcyc);
    end
  endtask

  task automatic test_store();
    int rq, dc, v; bit e, eh; exp_t x;
    model_access(1'b1, 1'b1, 32'h0, 32'h24, 3, 32'hFFFF_0000, x);
    run_access(1'b1, 1'b1, 32'h0, 32'h24, 32'h1234_5678, 3, 32'hFFFF_0000, 1'b0, rq, dc, e, eh, v);
    checks++; if (mdr !== 32'hDEAD_BEEF || instr !== m_instr) begin
      errors++; $display("FAIL store_regs got mdr=%h ir=%h exp deadbeef %h", mdr, instr, m_instr);
    end
    checks++; if (rq !== 3 || dc !== x.dcyc || v !== 0 || e !== 1'b0) begin
      errors++; $display("FAIL store_hs got req=%0d cyc=%0d viol=%0d err=%0d exp 3 %0d 0 0", rq, dc, v, e, x.dcyc);
    end
  endtask

  task automatic test_misaligned();
    int rq, dc, v; bit e, eh; exp_t x;
    model_access(1'b1, 1'b0, 32'h0, 32'h6, 1, 32'h5555_5555, x);
    run_access(1'b1, 1'b0, 32'h0, 32'h6, 32'h0, 1, 32'h5555_5555, 1'b0, rq, dc, e, eh, v);
    checks++; if (rq !== 0 || dc !== 1 || e !== 1'b1 || eh !== 1'b1) begin
      errors++; $display("FAIL misalign got req=%0d cyc=%0d err=%0d hold=%0d exp 0 1 1 1", rq, dc, e, eh);
    end
    checks++; if (mdr !== m_mdr || v !== 0) begin errors++; $display("FAIL misalign_mdr got %h viol=%0d exp %h 0", mdr, v, m_mdr); end
  endtask

  task automatic test_timeout();
    int rq, dc, v; bit e, eh; exp_t x;
    model_access(1'b0, 1'b0, 32'h40, 32'h0, 0, 32'h0, x);
    run_access(1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 0, 32'h0, 1'b0, rq, dc, e, eh, v);
    checks++; if (rq !== TO || dc !== TO + 1 || e !== 1'b1 || eh !== 1'b1 || v !== 0) begin
      errors++; $display("FAIL timeout got req=%0d cyc=%0d err=%0d hold=%0d viol=%0d exp 8 9 1 1 0", rq, dc, e, eh, v);
    end
    checks++; if (instr !== m_instr) begin errors++; $display("FAIL timeout_instr got %h exp %h", instr, m_instr); end
    model_access(1'b0, 1'b0, 32'h44, 32'h0, TO, 32'hCAFE_0001, x);
    run_access(1'b0, 1'b0, 32'h44, 32'h0, 32'h0, TO, 32'hCAFE_0001, 1'b0, rq, dc, e, eh, v);
    checks++; if (rq !== TO || dc !== TO + 1 || e !== 1'b0 || instr !== 32'hCAFE_0001) begin
      errors++; $display("FAIL late_ack got req=%0d cyc=%0d err=%0d ir=%h exp 8 9 0 cafe0001", rq, dc, e, instr);
    end
  endtask

  task automatic test_ack_idle();
    logic [31:0] ir0, md0;
    ir0 = m_instr; md0 = m_mdr;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    repeat (3) @(posedge clk);
    #1 mem_ack = 1'b0;
    @(negedge clk);
    checks++; if (instr !== ir0 || mdr !== md0 || done !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL ack_idle got ir=%h mdr=%h done=%0d req=%0d busy=%0d exp %h %h 0 0 0",
                         instr, mdr, done, mem_req, busy, ir0, md0);
    end
  endtask

  task automatic test_reset_mid();
    int rq, dc, v; bit e, eh; exp_t x;
    @(negedge clk);
    IorD = 1'b0; MemWrite = 1'b0; pc = 32'h100; acc_valid = 1'b1;
    @(posedge clk); #1 acc_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_req got %0d exp 1", mem_req); end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    m_instr = 32'h0; m_mdr = 32'h0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || instr !== 32'h0 || mdr !== 32'h0 || done !== 1'b0) begin
      errors++; $display("FAIL mid_reset got req=%0d busy=%0d ir=%h mdr=%h done=%0d exp 0 0 0 0 0",
                         mem_req, busy, instr, mdr, done);
    end
    model_access(1'b0, 1'b0, 32'h200, 32'h0, 2, 32'h0123_4567, x);
    run_access(1'b0, 1'b0, 32'h200, 32'h0, 32'h0, 2, 32'h0123_4567, 1'b0, rq, dc, e, eh, v);
    checks++; if (instr !== 32'h0123_4567 || dc !== 3 || e !== 1'b0 || v !== 0) begin
      errors++; $display("FAIL after_reset got ir=%h cyc=%0d err=%0d viol=%0d exp 01234567 3 0 0", instr, dc, e, v);
    end
  endtask

  task automatic test_random();
    int rq, dc, v, ack_at; bit e, eh, iord, mw, nz; exp_t x;
    logic [31:0] a_pc, a_alu, a_wd, rd;
    for (int i = 0; i < 40; i++) begin
      iord = 1'($urandom); mw = 1'($urandom); nz = 1'($urandom);
      a_pc  = $urandom & 32'hFFFF_FFFC;
      a_alu = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) begin
        if (iord) a_alu[1:0] = 2'($urandom_range(1, 3));
        else      a_pc[1:0]  = 2'($urandom_range(1, 3));
      end
      a_wd = $urandom; rd = $urandom;
      ack_at = $urandom_range(0, TO + 2);
      model_access(iord, mw, a_pc, a_alu, ack_at, rd, x);
      run_access(iord, mw, a_pc, a_alu, a_wd, ack_at, rd, nz, rq, dc, e, eh, v);
      checks++; if (rq !== x.req || dc !== x.dcyc) begin
        errors++; $display("FAIL rnd%0d_timing got req=%0d cyc=%0d exp %0d %0d", i, rq, dc, x.req, x.dcyc);
      end
      checks++; if (e !== x.err || eh !== x.err) begin
        errors++; $display("FAIL rnd%0d_err got err=%0d hold=%0d exp %0d", i, e, eh, x.err);
      end
      checks++; if (v !== 0) begin errors++; $display("FAIL rnd%0d_hs got viol=%0d exp 0", i, v); end
      checks++; if (instr !== m_instr || mdr !== m_mdr) begin
        errors++; $display("FAIL rnd%0d_regs got ir=%h mdr=%h exp %h %h", i, instr, mdr, m_instr, m_mdr);
      end
      checks++; if (Op !== m_instr[31:26] || Funct !== m_instr[5:0]) begin
        errors++; $display("FAIL rnd%0d_fields got op=%h fn=%h exp %h %h", i, Op, Funct, m_instr[31:26], m_instr[5:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_ack_idle();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
